// File: rtl/ifetcher_reqctrl_pkg.sv
// Shared definitions for the instruction-fetch request controller: state encoding,
// line geometry and default credit limits.
package ifetcher_reqctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int LINE_BYTES  = 16;
  localparam int DEF_BUF_CAP = 7;
  localparam int DEF_MAX_OUT = 4;
  localparam int CNT_W       = 3;

  function automatic logic [31:0] satInc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ifetcher_reqctrl_credit.sv
// Credit bookkeeping for the fetch path: buffer occupancy, outstanding requests and
// the count of stale requests whose responses must be discarded.
module ifetcher_reqctrl_credit
  import ifetcher_reqctrl_pkg::*;
#(
  parameter int MAX_OUT = DEF_MAX_OUT,
  parameter int BUF_CAP = DEF_BUF_CAP
) (
  input  logic iClk,
  input  logic iResetn,
  input  logic iAccept,
  input  logic iRspValid,
  input  logic iRedirect,
  input  logic iFlush,
  input  logic iBufRE,
  output logic oCreditOk,
  output logic oBufWE,
  output logic oDrop
);

  logic [CNT_W-1:0] occ, out, stale;
  logic             rspEff, rdEff;

  // A response with nothing outstanding is a bus protocol error and is ignored.
  assign rspEff = iRspValid && (out != '0);
  assign oDrop  = rspEff && ((stale != '0) || iRedirect || iFlush);
  assign oBufWE = rspEff && !oDrop;
  assign rdEff  = iBufRE && (occ != '0);

  // Widened so occ+out never wraps before the compare.
  assign oCreditOk = (({1'b0, occ} + {1'b0, out}) < 4'(BUF_CAP)) &&
                     (out < CNT_W'(MAX_OUT));

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      occ   <= '0;
      out   <= '0;
      stale <= '0;
    end else begin
      case ({iAccept, rspEff})
        2'b10:   out <= out + 1'b1;
        2'b01:   out <= out - 1'b1;
        default: out <= out;
      endcase

      if (iFlush) occ <= '0;
      else begin
        case ({oBufWE, rdEff})
          2'b10:   occ <= occ + 1'b1;
          2'b01:   occ <= occ - 1'b1;
          default: occ <= occ;
        endcase
      end

      // Everything in flight at redirect time is stale, minus a response landing now.
      if (iRedirect)                    stale <= out - {{(CNT_W-1){1'b0}}, rspEff};
      else if (oDrop && stale != '0)    stale <= stale - 1'b1;
    end
  end

endmodule

// File: rtl/ifetcher_reqctrl.sv
// Instruction fetch request controller: sequential line fetch, credit-limited issue,
// redirect flush. Optional perf counters via IFETCH_REQCTRL_PERF_EN.
module ifetcher_reqctrl
  import ifetcher_reqctrl_pkg::*;
#(
  parameter int             IW       = 32,
  parameter int             AW       = 32,
  parameter int             MAX_OUT  = DEF_MAX_OUT,
  parameter int             BUF_CAP  = DEF_BUF_CAP,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic            iClk,
  input  logic            iResetn,
  input  logic            iEnable,
  input  logic            iRedirect,
  input  logic [AW-1:0]   iRedirectPc,
  output logic            oReqValid,
  output logic [AW-1:0]   oReqAddr,
  input  logic            iReqReady,
  input  logic            iRspValid,
  input  logic [IW*4-1:0] iRspData,
  output logic            oBufWE,
  output logic [IW*4-1:0] oBufWD,
  output logic            oBufClear,
`ifdef IFETCH_REQCTRL_PERF_EN
  output logic [31:0]     oPerfReq,
  output logic [31:0]     oPerfDrop,
`endif
  input  logic            iBufRE
);

  localparam logic [AW-1:0] LINE_MASK = ~AW'(LINE_BYTES - 1);
  localparam logic [AW-1:0] PC_INIT   = RESET_PC & LINE_MASK;

  state_t        state;
  logic [AW-1:0] pc;
  logic          creditOk, accept, drop;

  ifetcher_reqctrl_credit #(
    .MAX_OUT(MAX_OUT),
    .BUF_CAP(BUF_CAP)
  ) uCredit (
    .iClk      (iClk),
    .iResetn   (iResetn),
    .iAccept   (accept),
    .iRspValid (iRspValid),
    .iRedirect (iRedirect),
    .iFlush    (state == FLUSH),
    .iBufRE    (iBufRE),
    .oCreditOk (creditOk),
    .oBufWE    (oBufWE),
    .oDrop     (drop)
  );

  // Redirect withdraws a pending request in the same cycle.
  assign oReqValid = (state == FETCH) && creditOk && !iRedirect;
  assign accept    = oReqValid && iReqReady;
  assign oReqAddr  = pc;
  assign oBufClear = (state == FLUSH);
  assign oBufWD    = oBufWE ? iRspData : '0;

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      state <= IDLE;
      pc    <= PC_INIT;
    end else if (iRedirect) begin
      state <= FLUSH;
      pc    <= iRedirectPc & LINE_MASK;
    end else begin
      if (accept) pc <= pc + AW'(LINE_BYTES);
      case (state)
        IDLE:    if (iEnable) state <= FETCH;
        // Never drop out of FETCH with a request still waiting on the bus.
        FETCH:   if (!iEnable && !(oReqValid && !iReqReady)) state <= IDLE;
        FLUSH:   state <= iEnable ? FETCH : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IFETCH_REQCTRL_PERF_EN
  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      oPerfReq  <= '0;
      oPerfDrop <= '0;
    end else begin
      if (accept) oPerfReq  <= satInc32(oPerfReq);
      if (drop)   oPerfDrop <= satInc32(oPerfDrop);
    end
  end
`else
  logic unusedDrop;
  assign unusedDrop = drop;
`endif

endmodule
